// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared widths, vector types and FSM states for the vector MEM sequencer
package vec_pkg;
    localparam int N      = 32;
    localparam int V      = 20;
    localparam int STRIDE = 4;
    localparam int LW     = $clog2(V);

    typedef logic [N-1:0]         word_t;
    typedef logic [V-1:0][N-1:0]  vec_t;
    typedef logic [LW-1:0]        lane_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/vec_lane_counter.sv
// rtl/vec_lane_counter.sv - lane index counter with clear, increment and last-lane flag
module vec_lane_counter
    import vec_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  inc,
    output lane_t count,
    output logic  last_o
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign last_o = (count == lane_t'(V - 1));
endmodule

// File: rtl/vec_mem_sequencer.sv
// rtl/vec_mem_sequencer.sv - serialises vector loads/stores over the 32-bit data port, one lane per cycle
module vec_mem_sequencer
    import vec_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  start_i,
    input  logic  we_i,
    input  word_t base_addr_i,
    input  vec_t  wdata_v_i,
    input  word_t mem_rdata_i,
    output word_t mem_addr_o,
    output word_t mem_wdata_o,
    output logic  mem_we_o,
    output logic  stall_o,
    output lane_t lane_o,
    output vec_t  rdata_v_o,
    output logic  done_o
);
    state_t state;
    word_t  base_lat;
    logic   we_lat;
    vec_t   wdata_lat;
    vec_t   lane_buf;
    lane_t  lane;
    logic   last;

    vec_lane_counter u_lane (
        .clk    (CLK),
        .rst    (RST),
        .clr    (state == IDLE && start_i),
        .inc    (state == BUSY && !last),
        .count  (lane),
        .last_o (last)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            base_lat  <= '0;
            we_lat    <= 1'b0;
            wdata_lat <= '0;
            lane_buf  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        base_lat  <= base_addr_i;
                        we_lat    <= we_i;
                        wdata_lat <= wdata_v_i;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (!we_lat) begin
                        lane_buf[lane] <= mem_rdata_i;
                    end
                    if (last) begin
                        state <= DONE;
                    end
                end
                // start_i is deliberately not looked at here; a held request is taken next cycle in IDLE
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = 1'b0;
        stall_o     = 1'b0;
        done_o      = 1'b0;
        case (state)
            IDLE: stall_o = start_i;
            BUSY: begin
                stall_o     = 1'b1;
                mem_addr_o  = base_lat + word_t'(lane) * word_t'(STRIDE);
                mem_we_o    = we_lat;
                mem_wdata_o = wdata_lat[lane];
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    assign lane_o    = lane;
    assign rdata_v_o = lane_buf;
endmodule

// File: tb/tb_vec_mem_sequencer.sv
// tb/tb_vec_mem_sequencer.sv - table and scoreboard driven bench for vec_mem_sequencer
module tb_vec_mem_sequencer;
    import vec_pkg::*;

    logic  CLK = 1'b0;
    logic  RST;
    logic  start_i;
    logic  we_i;
    word_t base_addr_i;
    vec_t  wdata_v_i;
    word_t mem_rdata_i;
    word_t mem_addr_o;
    word_t mem_wdata_o;
    logic  mem_we_o;
    logic  stall_o;
    lane_t lane_o;
    vec_t  rdata_v_o;
    logic  done_o;
    word_t rd_key;

    int checks = 0;
    int failures = 0;

    vec_mem_sequencer dut (
        .CLK         (CLK),
        .RST         (RST),
        .start_i     (start_i),
        .we_i        (we_i),
        .base_addr_i (base_addr_i),
        .wdata_v_i   (wdata_v_i),
        .mem_rdata_i (mem_rdata_i),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_we_o    (mem_we_o),
        .stall_o     (stall_o),
        .lane_o      (lane_o),
        .rdata_v_o   (rdata_v_o),
        .done_o      (done_o)
    );

    always #5 CLK = ~CLK;

    // memory returns a keyed function of the address so each lane's data is distinct
    assign mem_rdata_i = mem_addr_o ^ rd_key;

    typedef struct {
        logic        we;
        logic [31:0] base;
        logic [31:0] key;
        logic [31:0] wbias;
        logic [31:0] addr2;
        logic [31:0] addr3;
        int          we_cycles;
    } op_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        stall;
        logic        done;
    } cyc_t;

    op_t  ops[4];
    cyc_t sb[$];
    vec_t exp_buf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkw(input logic [31:0] bias);
        vec_t w;
        for (int k = 0; k < V; k++) w[k] = bias + 32'(k);
        return w;
    endfunction

    task automatic chk_buf(input string nm);
        for (int k = 0; k < V; k++) chk(nm, rdata_v_o[k], exp_buf[k]);
    endtask

    task automatic run_op(input op_t op);
        cyc_t e;
        cyc_t g;
        int   wc = 0;
        logic [31:0] a2 = '0;
        logic [31:0] a3 = '0;
        @(negedge CLK);
        start_i     = 1'b1;
        we_i        = op.we;
        base_addr_i = op.base;
        wdata_v_i   = mkw(op.wbias);
        rd_key      = op.key;
        e = '{addr: 32'h0, we: 1'b0, wdata: 32'h0, stall: 1'b1, done: 1'b0};
        sb.push_back(e);
        for (int k = 0; k < V; k++) begin
            e = '{addr: op.base + 32'(4 * k), we: op.we, wdata: op.wbias + 32'(k), stall: 1'b1, done: 1'b0};
            sb.push_back(e);
        end
        e = '{addr: 32'h0, we: 1'b0, wdata: 32'h0, stall: 1'b0, done: 1'b1};
        sb.push_back(e);
        for (int c = 0; c < V + 2; c++) begin
            if (c > 0) @(negedge CLK);
            if (c == 1) begin
                // disturb every latched input while the op is in flight
                start_i     = 1'b0;
                we_i        = ~op.we;
                base_addr_i = $urandom;
                wdata_v_i   = mkw($urandom);
            end
            #1;
            g = sb.pop_front();
            chk("addr", mem_addr_o, g.addr);
            chk("we", 32'(mem_we_o), 32'(g.we));
            chk("wdata", mem_wdata_o, g.wdata);
            chk("stall", 32'(stall_o), 32'(g.stall));
            chk("done", 32'(done_o), 32'(g.done));
            if (mem_we_o) wc++;
            if (c == 3) a2 = mem_addr_o;
            if (c == 4) a3 = mem_addr_o;
        end
        chk("we_cycles", 32'(wc), 32'(op.we_cycles));
        chk("lane2_addr", a2, op.addr2);
        chk("lane3_addr", a3, op.addr3);
        if (!op.we) begin
            for (int k = 0; k < V; k++) exp_buf[k] = (op.base + 32'(4 * k)) ^ op.key;
        end
        @(negedge CLK);
        #1;
        chk_buf("rdata_v");
    endtask

    initial begin
        int found;
        int wr_hi;
        int d1;
        int d2;
        ops[0] = '{1'b0, 32'h0000_0100, 32'hA5A5_A5A5, 32'h0000_0000, 32'h0000_0108, 32'h0000_010C, 0};
        ops[1] = '{1'b1, 32'h0000_0200, 32'h0000_0000, 32'h0000_0001, 32'h0000_0208, 32'h0000_020C, 20};
        ops[2] = '{1'b0, 32'hFFFF_FFF8, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 0};
        ops[3] = '{1'b1, 32'hFFFF_FFF8, 32'h0000_0000, 32'hDEAD_0000, 32'h0000_0000, 32'h0000_0004, 20};

        RST = 1'b1; start_i = 1'b0; we_i = 1'b0; base_addr_i = '0; wdata_v_i = '0; rd_key = '0;
        exp_buf = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst_we", 32'(mem_we_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        chk("rst_lane", 32'(lane_o), 32'h0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk_buf("rst_rdata");

        for (int i = 0; i < 4; i++) run_op(ops[i]);

        // scalar traffic only
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            #1;
            chk("scalar_stall", 32'(stall_o), 32'h0);
            chk("scalar_we", 32'(mem_we_o), 32'h0);
            chk("scalar_done", 32'(done_o), 32'h0);
        end

        // reset in the middle of a store at lane 7
        @(negedge CLK);
        start_i = 1'b1; we_i = 1'b1; base_addr_i = 32'h0000_0300; wdata_v_i = mkw(32'h5500_0000);
        found = 0;
        for (int c = 0; c < 30 && found == 0; c++) begin
            @(negedge CLK);
            start_i = 1'b0;
            #1;
            if (lane_o == lane_t'(7) && stall_o) found = 1;
        end
        chk("rst_mid_found", 32'(found), 32'h1);
        chk("rst_mid_addr7", mem_addr_o, 32'h0000_031C);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        exp_buf = '0;
        chk("rst_mid_stall", 32'(stall_o), 32'h0);
        chk("rst_mid_we", 32'(mem_we_o), 32'h0);
        chk("rst_mid_lane", 32'(lane_o), 32'h0);
        chk_buf("rst_mid_rdata");
        wr_hi = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge CLK);
            #1;
            if (mem_we_o && mem_addr_o >= 32'h0000_0320) wr_hi++;
        end
        chk("rst_mid_late_writes", 32'(wr_hi), 32'h0);

        // two loads with start_i held high
        @(negedge CLK);
        start_i = 1'b1; we_i = 1'b0; base_addr_i = 32'h0000_0400; rd_key = 32'h0F0F_0F0F;
        d1 = -1; d2 = -1;
        for (int c = 0; c < 80; c++) begin
            if (c > 0) @(negedge CLK);
            #1;
            if (d1 >= 0 && c == d1 + 1) chk("b2b_restart_stall", 32'(stall_o), 32'h1);
            if (done_o) begin
                if (d1 < 0) begin
                    d1 = c;
                    rd_key = 32'h3C3C_C3C3;
                end else if (d2 < 0) begin
                    d2 = c;
                    start_i = 1'b0;
                end
            end
        end
        chk("b2b_first_done", 32'(d1), 32'd21);
        chk("b2b_spacing", 32'(d2 - d1), 32'd22);
        for (int k = 0; k < V; k++) exp_buf[k] = (32'h0000_0400 + 32'(4 * k)) ^ 32'h3C3C_C3C3;
        chk_buf("b2b_rdata");
        chk("b2b_idle_stall", 32'(stall_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
